fp8_div_seq: RTL and testbench

//  Sequential divider for the team's 8-bit float format {sign[7], exp[6:4] biased, frac[3:0] hidden-1}.

---
 rtl/fp8_pkg.sv | 26 ++
 rtl/fp8_div_step.sv | 25 ++
 rtl/fp8_div_seq.sv | 151 +++++++++++++++
 tb/tb_fp8_div_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fp8_pkg.sv
// Shared definitions for the 8-bit float datapath {sign[7], exp[6:4], frac[3:0]}.
// Optional feature macro: FP8_DIV_ROUND_EN (one extra quotient bit, round half-up).
package fp8_pkg;

  localparam int SIGN_BIT = 7;
  localparam int EXP_MSB  = 6;
  localparam int EXP_LSB  = 4;
  localparam int FRAC_MSB = 3;
  localparam int FRAC_LSB = 0;

  localparam logic [2:0] BIAS_DEFAULT = 3'd3;

`ifdef FP8_DIV_ROUND_EN
  localparam int ITER = 7;
`else
  localparam int ITER = 6;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fp8_div_step.sv
// One restoring division iteration: trial-subtract the divisor, emit the
// quotient bit, then shift the partial remainder left by one.
module fp8_div_step (
  input  logic [5:0] r,
  input  logic [4:0] d,
  output logic [5:0] r_next,
  output logic       q
);

  logic [4:0] diff_s;

  // Keep the subtraction only when the divisor fits; remainder stays below d,
  // so only its low five bits survive the shift
  always_comb begin
    diff_s = r[4:0] - d;
    if (r >= {1'b0, d}) begin
      q      = 1'b1;
      r_next = {diff_s, 1'b0};
    end else begin
      q      = 1'b0;
      r_next = {r[4:0], 1'b0};
    end
  end

endmodule

// File: rtl/fp8_div_seq.sv
// Sequential fp8 divider res = op1 / op2, one quotient bit per clock.
// FSM IDLE -> DIV (ITER cycles) -> NORM -> DONE -> IDLE; outputs are registered
// from the current state, so they trail the state by one clock.
// Optional feature macro: FP8_DIV_ROUND_EN (ITER=7, round half-up on the guard bit).
module fp8_div_seq
  import fp8_pkg::*;
#(
  parameter logic [2:0] BIAS = BIAS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] op1,
  input  logic [7:0] op2,
  output logic       busy,
  output logic       done,
  output logic [7:0] res
);

  localparam logic [2:0] LAST_CNT = 3'(ITER - 1);

  state_t          state_r, state_s;
  logic [5:0]      rem_r;
  logic [4:0]      div_r;
  logic [ITER-1:0] quo_r;
  logic [2:0]      exp_r;
  logic            sign_r;
  logic [2:0]      cnt_r;
  logic [3:0]      mant_r;

  logic [5:0]      rem_next_s;
  logic            q_s;
  logic [3:0]      mant_s;
  logic [2:0]      exp_norm_s;
`ifdef FP8_DIV_ROUND_EN
  logic            guard_s;
  logic [4:0]      mant_sum_s;
`endif

  logic            busy_r, done_r;
  logic [7:0]      res_r;

  fp8_div_step u_step (
    .r      (rem_r),
    .d      (div_r),
    .r_next (rem_next_s),
    .q      (q_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic; start is only honoured in IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start) state_s = DIV; else state_s = IDLE;
      DIV:     if (cnt_r == LAST_CNT) state_s = NORM; else state_s = DIV;
      NORM:    state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Normalise the quotient into a 4-bit mantissa, optionally rounding on the guard bit
  always_comb begin
    mant_s     = 4'd0;
    exp_norm_s = exp_r;
`ifdef FP8_DIV_ROUND_EN
    guard_s    = 1'b0;
    mant_sum_s = 5'd0;
`endif
    if (quo_r[ITER-1]) begin
      mant_s = quo_r[ITER-2 -: 4];
`ifdef FP8_DIV_ROUND_EN
      guard_s = quo_r[ITER-6];
`endif
    end else begin
      mant_s     = quo_r[ITER-3 -: 4];
      exp_norm_s = exp_r - 3'd1;
`ifdef FP8_DIV_ROUND_EN
      guard_s = quo_r[ITER-7];
`endif
    end
`ifdef FP8_DIV_ROUND_EN
    mant_sum_s = {1'b0, mant_s} + {4'd0, guard_s};
    mant_s     = mant_sum_s[3:0];
    if (mant_sum_s[4]) exp_norm_s = exp_norm_s + 3'd1;
    else               exp_norm_s = exp_norm_s;
`endif
  end

  // Operand capture, one restoring step per DIV cycle, normalisation in NORM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_r  <= 6'd0;
      div_r  <= 5'd0;
      quo_r  <= '0;
      exp_r  <= 3'd0;
      sign_r <= 1'b0;
      cnt_r  <= 3'd0;
      mant_r <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            sign_r <= op1[SIGN_BIT] ^ op2[SIGN_BIT];
            rem_r  <= {1'b0, 1'b1, op1[FRAC_MSB:FRAC_LSB]};
            div_r  <= {1'b1, op2[FRAC_MSB:FRAC_LSB]};
            quo_r  <= '0;
            exp_r  <= op1[EXP_MSB:EXP_LSB] - op2[EXP_MSB:EXP_LSB] + BIAS;
            cnt_r  <= 3'd0;
          end
        end
        DIV: begin
          rem_r <= rem_next_s;
          quo_r <= {quo_r[ITER-2:0], q_s};
          cnt_r <= cnt_r + 3'd1;
        end
        NORM: begin
          exp_r  <= exp_norm_s;
          mant_r <= mant_s;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Registered handshake and result; res holds until the next completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      res_r  <= 8'd0;
    end else begin
      busy_r <= (state_r == DIV) || (state_r == NORM);
      done_r <= (state_r == DONE);
      if (state_r == DONE) res_r <= {sign_r, exp_r, mant_r};
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign res  = res_r;

endmodule

// File: tb/tb_fp8_div_seq.sv
// Self-checking bench for fp8_div_seq: directed cases, handshake timing,
// mid-operation reset and randomized operands against an arithmetic model.
// Honours FP8_DIV_ROUND_EN the same way the design does.
module tb_fp8_div_seq;

`ifdef FP8_DIV_ROUND_EN
  localparam int ITER = 7;
  localparam logic [7:0] EXP_1_125 = 8'h2A;
`else
  localparam int ITER = 6;
  localparam logic [7:0] EXP_1_125 = 8'h29;
`endif
  localparam int LAT = ITER + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] op1, op2;
  logic       busy, done;
  logic [7:0] res;

  int checks = 0;
  int errors = 0;

  fp8_div_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op1   (op1),
    .op2   (op2),
    .busy  (busy),
    .done  (done),
    .res   (res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer quotient of the 1.frac significands, then
  // keep five significant bits (hidden one + 4 frac) and adjust the exponent.
  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b);
    int n, d, q, e, keep;
    logic s;
    s = a[7] ^ b[7];
    n = 16 + int'(a[3:0]);
    d = 16 + int'(b[3:0]);
    q = (n * (1 << (ITER - 1))) / d;
    e = int'(a[6:4]) - int'(b[6:4]) + 3;
    if (q >= (1 << (ITER - 1))) begin
      keep = q >> (ITER - 5);
`ifdef FP8_DIV_ROUND_EN
      keep = keep + ((q >> (ITER - 6)) & 1);
`endif
    end else begin
      keep = q >> (ITER - 6);
      e = e - 1;
`ifdef FP8_DIV_ROUND_EN
      keep = keep + ((q >> (ITER - 7)) & 1);
`endif
    end
    if (keep >= 32) begin
      keep = 16;
      e = e + 1;
    end
    model = {s, 3'(e & 7), 4'(keep & 15)};
  endfunction

  // Launch one division and check latency, busy width, result and pulse width
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_res, input string tag);
    int lat_seen;
    int busy_cnt;
    @(negedge clk);
    op1 = a; op2 = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat_seen = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        lat_seen = k;
        break;
      end
    end
    check({tag, "_latency"}, lat_seen, LAT);
    check({tag, "_res"}, res, exp_res);
    check({tag, "_busy_cycles"}, busy_cnt, LAT - 1);
    check({tag, "_busy_low_at_done"}, busy, 1'b0);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_res_hold"}, res, exp_res);
  endtask

  logic [7:0] ra, rb;
  int         lat_seen;

  initial begin
    rst = 1'b1; start = 1'b0; op1 = 8'h00; op2 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_res", res, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op(8'h48, 8'h38, 8'h40, "d_3_over_1p5");
    run_op(8'h30, 8'h30, 8'h30, "d_1_over_1");
    run_op(8'hB0, 8'h30, 8'hB0, "d_neg_over_pos");
    run_op(8'hB0, 8'hB0, 8'h30, "d_neg_over_neg");
    run_op(8'h30, 8'h38, 8'h25, "d_1_over_1p5");
    run_op(8'h30, 8'h34, EXP_1_125, "d_1_over_1p25");
    run_op(8'h00, 8'h70, 8'h40, "d_exp_wrap");
    run_op(8'h3F, 8'h30, model(8'h3F, 8'h30), "d_max_frac");

    // start held high with changed operands while busy: must be ignored
    @(negedge clk);
    op1 = 8'h48; op2 = 8'h38; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op1 = 8'h30; op2 = 8'h38;
    lat_seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat_seen = k;
        break;
      end
    end
    start = 1'b0;
    check("hold_latency", lat_seen, LAT);
    check("hold_res_first_ops", res, 8'h40);
    repeat (2) @(posedge clk);
    #1;
    check("hold_not_queued", busy, 1'b0);

    // Reset pulsed during the third DIV cycle
    @(negedge clk);
    op1 = 8'h30; op2 = 8'h34; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_reset_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_res", res, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    #1;
    check("abort_no_done", done, 1'b0);
    check("abort_res_stays_zero", res, 8'h00);
    run_op(8'h48, 8'h38, 8'h40, "after_abort");

    // Randomized operands against the model
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(ra, rb, model(ra, rb), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
